// File: rtl/pprr_141088.sv
// -----------------------------------------------------------------------------
// pprr_141088 -- partial-product reduction-and-resolve stage of a 4x4 signed
// (two's-complement) modified Baugh-Wooley multiplier.
//
// The upstream generator supplies four 4-bit rows with the Baugh-Wooley
// complements already applied. This block compresses those rows, plus the
// correction constant 8'h90, through a carry-save tree down to two rows. An
// 8-bit ripple-carry adder then resolves the two rows. Only the result
// register is sequential, so latency is exactly one cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (priority over in_valid)
//   in_valid   pp0..pp3 carry a valid set of rows this cycle
//   pp3..pp0   partial-product rows; row i bit j has weight 2^(i+j)
//   y          registered signed product (holds while in_valid is low)
//   out_valid  y was loaded with a new result on the last edge
// -----------------------------------------------------------------------------
module pprr_141088 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] pp3,
    input  logic [3:0] pp2,
    input  logic [3:0] pp1,
    input  logic [3:0] pp0,
    output logic [7:0] y,
    output logic       out_valid
);

    // Half adder and full adder cells. Each returns {carry, sum}.
    function automatic logic [1:0] ha(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Initial column heights, including the correction bits at 4 and 7:
    //   col: 7 6 5 4 3 2 1 0
    //   h  : 1 1 2 4 4 3 2 1
    // Stage 1 reduces the tree to a maximum height of 3, and stage 2 reduces it to 2.

    // Stage 1
    logic [1:0] s1_c3;   // HA on column 3
    logic [1:0] s1_c4;   // FA on column 4

    assign s1_c3 = ha(pp0[3], pp1[2]);
    assign s1_c4 = fa(pp1[3], pp2[2], pp3[1]);

    // Stage 2
    logic [1:0] s2_c2;
    logic [1:0] s2_c3;
    logic [1:0] s2_c4;
    logic [1:0] s2_c5;

    assign s2_c2 = fa(pp0[2], pp1[1], pp2[0]);
    assign s2_c3 = fa(s1_c3[0], pp2[1], pp3[0]);
    // The correction bit at weight 2^4 enters the tree here as a constant FA input.
    assign s2_c4 = fa(s1_c4[0], 1'b1, s1_c3[1]);
    assign s2_c5 = fa(pp2[3], pp3[2], s1_c4[1]);

    // Two remaining rows. The correction bit at weight 2^7 rides in row_a[7].
    logic [7:0] row_a;
    logic [7:0] row_b;

    assign row_a = {1'b1, pp3[3], s2_c5[0], s2_c4[0], s2_c3[0], s2_c2[0], pp0[1], pp0[0]};
    assign row_b = {1'b0, s2_c5[1], s2_c4[1], s2_c3[1], s2_c2[1], 1'b0, pp1[0], 1'b0};

    // Ripple-carry resolve. The carry out of bit 7 is dropped, which gives the
    // mod-256 wrap, so bit 7 needs only its sum.
    logic [7:0] rc;
    logic [7:0] y_d;

    assign rc[0] = 1'b0;

    for (genvar k = 0; k < 7; k++) begin : g_rca
        assign {rc[k+1], y_d[k]} = fa(row_a[k], row_b[k], rc[k]);
    end

    assign y_d[7] = row_a[7] ^ row_b[7] ^ rc[7];

    // Output register
    logic [7:0] y_q;
    logic       out_valid_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q         <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                y_q <= y_d;
            end
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pprr_141088.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pprr_141088. Expected results come from a reference
// Baugh-Wooley row generator and plain integer products, or from the weighted
// row sum with the correction constant when raw rows are applied.
// -----------------------------------------------------------------------------
module tb_pprr_141088;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] pp3, pp2, pp1, pp0;
    logic [7:0] y;
    logic       out_valid;

    int n_vec;
    int n_err;

    pprr_141088 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .pp3       (pp3),
        .pp2       (pp2),
        .pp1       (pp1),
        .pp0       (pp0),
        .y         (y),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference models

    // Two's-complement value of a 4-bit operand.
    function automatic int sval4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Baugh-Wooley row generator, returns {pp3, pp2, pp1, pp0}.
    function automatic logic [15:0] bw_rows(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r [4];
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) r[i][j] = a[j] & b[i];
            r[i][3] = ~(a[3] & b[i]);
        end
        for (int j = 0; j < 3; j++) r[3][j] = ~(a[j] & b[3]);
        r[3][3] = a[3] & b[3];
        return {r[3], r[2], r[1], r[0]};
    endfunction

    // Weighted row sum plus correction, modulo 256.
    function automatic logic [7:0] row_model(input logic [15:0] rows);
        int s;
        s = int'(rows[3:0]) + 2 * int'(rows[7:4]) + 4 * int'(rows[11:8])
          + 8 * int'(rows[15:12]) + 144;
        return 8'(s % 256);
    endfunction

    // Stimulus helpers

    task automatic drive(input logic [15:0] rows, input logic v);
        {pp3, pp2, pp1, pp0} = rows;
        in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tests

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(16'($urandom), 1'b1);
            tick();
            n_vec++;
            if (y !== 8'h00 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: y=%h ov=%b, want y=00 ov=0", c, y, out_valid);
            end
        end
        // The first valid input after release gives 3 * -2 = -6.
        rst_n = 1'b1;
        drive(bw_rows(4'd3, 4'hE), 1'b1);
        tick();
        n_vec++;
        if (y !== 8'hFA || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: y=%h ov=%b, want y=fa ov=1", y, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] rows [3];
        logic [7:0]  exp  [3];
        rows[0] = {4'b0111, 4'b1000, 4'b1000, 4'b1000}; exp[0] = 8'h00; // 0*0
        rows[1] = {4'b0111, 4'b1000, 4'b1000, 4'b0111}; exp[1] = 8'hFF; // -1*1
        rows[2] = {4'b1111, 4'b1000, 4'b1000, 4'b1000}; exp[2] = 8'h40; // -8*-8
        for (int i = 0; i < 3; i++) begin
            drive(rows[i], 1'b1);
            tick();
            n_vec++;
            if (y !== exp[i] || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL directed_%0d: y=%h ov=%b, want y=%h ov=1", i, y, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive(16'h5555, 1'b1);
        tick();
        n_vec++;
        if (y !== 8'hDB || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL raw_5555: y=%h ov=%b, want y=db ov=1", y, out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            drive(16'($urandom), 1'b0);
            tick();
            n_vec++;
            if (y !== 8'hDB || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cyc%0d: y=%h ov=%b, want y=db ov=0", c, y, out_valid);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] exp;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(bw_rows(4'(a), 4'(b)), 1'b1);
                exp = 8'(sval4(4'(a)) * sval4(4'(b)));
                tick();
                n_vec++;
                if (y !== exp || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL exh a=%0d b=%0d: y=%h ov=%b, want y=%h ov=1",
                             sval4(4'(a)), sval4(4'(b)), y, out_valid, exp);
                end
            end
        end
    endtask

    task automatic test_random_rows();
        logic [15:0] rows;
        logic        v;
        logic [7:0]  exp_y;
        exp_y = y;  // retained value carried over from the previous test
        for (int c = 0; c < 300; c++) begin
            rows = 16'($urandom);
            v    = 1'($urandom_range(0, 3) != 0);
            drive(rows, v);
            if (v) exp_y = row_model(rows);
            tick();
            n_vec++;
            if (y !== exp_y || out_valid !== v) begin
                n_err++;
                $display("FAIL rand_cyc%0d rows=%h v=%b: y=%h ov=%b, want y=%h ov=%b",
                         c, rows, v, y, out_valid, exp_y, v);
            end
        end
    endtask

    task automatic test_midstream_reset();
        // Reset arrives on the same edge as a valid input, which must be discarded.
        drive(bw_rows(4'd7, 4'd7), 1'b1);
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (y !== 8'h00 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: y=%h ov=%b, want y=00 ov=0", y, out_valid);
        end
        rst_n = 1'b1;
        drive(16'($urandom), 1'b0);
        tick();
        n_vec++;
        if (y !== 8'h00 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: y=%h ov=%b, want y=00 ov=0", y, out_valid);
        end
        // 7 * -5 = -35 = 0xDD
        drive(bw_rows(4'd7, 4'hB), 1'b1);
        tick();
        n_vec++;
        if (y !== 8'hDD || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_first: y=%h ov=%b, want y=dd ov=1", y, out_valid);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        {pp3, pp2, pp1, pp0} = '0;
        #2;
        test_reset();
        test_directed();
        test_hold();
        test_exhaustive();
        test_random_rows();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pprr_141088.md
Name: pprr_141088

Overview:
- Partial-product reduction-and-resolve stage of a 4x4 signed (two's-complement) multiplier using modified Baugh-Wooley.
- Takes four 4-bit partial-product rows from the upstream generator, which has already applied the Baugh-Wooley complements. Reduces the rows through a carry-save tree, adds the Baugh-Wooley correction constant, and resolves to an 8-bit signed product.
- The result is registered, giving one cycle of latency.

Parameters:
- None. Widths are fixed: 4 rows of 4 bits in, 8 bits out.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  the pp0..pp3 inputs are valid this cycle
- pp3  input  4  row 3, weight 2^(3+j) for bit j
- pp2  input  4  row 2, weight 2^(2+j)
- pp1  input  4  row 1, weight 2^(1+j)
- pp0  input  4  row 0, weight 2^j
- y  output  8  signed product, two's-complement
- out_valid  output  1  y holds a new result

Behaviour:
- Row content supplied upstream, for operands a and b:
  - Rows 0-2: bits 0-2 = a[j]&b[i]; bit 3 = ~(a[3]&b[i]).
  - Row 3: bits 0-2 = ~(a[j]&b[3]); bit 3 = a[3]&b[3].
- Arithmetic:
  - y_next = (pp0 + (pp1<<1) + (pp2<<2) + (pp3<<3) + 8'h90) mod 256.
  - 8'h90 is the correction constant: 1 at bit 4 plus 1 at bit 7.
  - All rows are treated as unsigned bit-vectors. Carries out of bit 7 are discarded.
- Structure:
  - Explicit half-adder/full-adder carry-save (Dadda/Wallace) reduction of the bit columns, including the constant bits, down to two rows.
  - Then an 8-bit ripple-carry final adder. Do not use a behavioural "+".
  - The reduction is combinational. Only the output stage is registered.
- Timing:
  - On a rising edge with rst_n=1 and in_valid=1: y <= y_next, out_valid <= 1.
  - On a rising edge with rst_n=1 and in_valid=0: y holds its value, out_valid <= 0.
  - Latency is exactly 1 cycle. Back-to-back valid inputs give one result per cycle.
- Reset:
  - On a rising edge with rst_n=0: y <= 8'h00, out_valid <= 0.
  - Reset has priority over in_valid.
  - Reset asserted mid-stream discards the in-flight result. The first valid input after release produces a result one cycle later.
- Boundaries:
  - Overflow wraps modulo 2^8.
  - The only product that reaches the extreme is (-8)*(-8)=+64, which fits in 8 bits.
  - X/Z on the pp inputs is not required to be handled.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and random pp -> y=8'h00 and out_valid=0. After release, the first valid input gives a result after 1 cycle.
- a=0, b=0: pp0=pp1=pp2=4'b1000, pp3=4'b0111, in_valid=1 -> next cycle y=8'h00, out_valid=1.
- a=-1, b=1: pp0=4'b0111, pp1=pp2=4'b1000, pp3=4'b0111 -> y=8'hFF (-1).
- a=-8, b=-8: pp0=pp1=pp2=4'b1000, pp3=4'b1111 -> y=8'h40 (+64).
- Raw rows: pp3=pp2=pp1=pp0=4'b0101 -> y=8'hDB. Then in_valid=0 for 3 cycles -> y stays 8'hDB and out_valid=0.
- Exhaustive: all 256 (a,b) pairs run back-to-back through a reference Baugh-Wooley row generator -> each y equals a*b as 8-bit two's-complement, one cycle after its input, with out_valid=1 on every cycle.
